deserializer_mod: RTL and testbench

//  Receive end of the electrode-configuration serial link: rebuilds an N_ELECTRODES-bit word from

---
 rtl/deserializer_mod.sv | 109 ++++++++++
 tb/tb_deserializer_mod.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/deserializer_mod.sv
// Receive side of the electrode-configuration serial link.
// Rebuilds, qualifies and commits N_ELECTRODES-bit frames.
module deserializer_mod #(
  parameter int N_ELECTRODES = 55,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    serial_in,
  input  logic                    enable_config,
  output logic [N_ELECTRODES-1:0] electr_config_out,
  output logic                    config_valid,
  output logic                    frame_error,
  output logic                    rx_busy,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int BW = $clog2(N_ELECTRODES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    ERR_WAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N_ELECTRODES-1:0] r_shift;
  logic [N_ELECTRODES-1:0] w_shift_in;
  logic [BW-1:0]           r_cnt;
  logic                    w_sample;
  logic                    w_commit;
  logic                    w_err;

  assign w_shift_in = MSB_FIRST
    ? {r_shift[N_ELECTRODES-2:0], serial_in}
    : {serial_in, r_shift[N_ELECTRODES-1:1]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_config) begin
          w_sample    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (enable_config) begin
          w_sample = 1'b1;
          if (r_cnt == BW'(N_ELECTRODES - 1))
            w_state_nxt = CHECK;
        end else begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CHECK: begin
        // Envelope still high after N bits means an overlong frame
        if (enable_config) begin
          w_err       = 1'b1;
          w_state_nxt = ERR_WAIT;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ERR_WAIT: begin
        if (!enable_config) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift           <= '0;
      r_cnt             <= '0;
      electr_config_out <= '0;
      config_valid      <= 1'b0;
      frame_error       <= 1'b0;
      rx_busy           <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      config_valid <= w_commit;
      frame_error  <= w_err;
      rx_busy      <= (w_state_nxt != IDLE);
      if (w_sample) begin
        r_shift <= w_shift_in;
        r_cnt   <= (r_state == IDLE) ? BW'(1) : r_cnt + BW'(1);
      end
      if (w_commit) begin
        electr_config_out <= r_shift;
        frame_cnt         <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_deserializer_mod.sv
// Bench for deserializer_mod: table of frames, scoreboard of
// expected commits/errors, plus reset and bit-order corner cases.
module tb_deserializer_mod;

  localparam int N = 55;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          si;
  logic          en;
  logic [N-1:0]  out_m;
  logic          cv_m;
  logic          fe_m;
  logic          busy_m;
  logic [15:0]   cnt_m;
  logic [N-1:0]  out_l;
  logic          cv_l;
  logic          fe_l;
  logic          busy_l;
  logic [1:0]    cnt_l;

  always #5 CLK = ~CLK;

  deserializer_mod #(.N_ELECTRODES(N), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .serial_in(si), .enable_config(en),
    .electr_config_out(out_m), .config_valid(cv_m),
    .frame_error(fe_m), .rx_busy(busy_m), .frame_cnt(cnt_m)
  );

  deserializer_mod #(.N_ELECTRODES(N), .MSB_FIRST(1'b0), .CNT_W(2)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N),
    .serial_in(si), .enable_config(en),
    .electr_config_out(out_l), .config_valid(cv_l),
    .frame_error(fe_l), .rx_busy(busy_l), .frame_cnt(cnt_l)
  );

  typedef struct {
    logic [N-1:0] word;
    int           len;
    int           gap;
    bit           commit;
  } vec_t;

  typedef struct {
    bit           commit;
    logic [N-1:0] word;
  } ev_t;

  ev_t          sb[$];
  logic [N-1:0] exp_out;
  int           exp_cnt;
  int           nchk;
  int           nerr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  // Scoreboard: every pulse must match the oldest pending frame outcome
  always @(negedge CLK) begin
    ev_t ev;
    if (RST_N && (cv_m || fe_m)) begin
      chk("pulse_exclusive", {63'd0, cv_m & fe_m}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'd0, cv_m, fe_m}, 64'd0);
      end else begin
        ev = sb.pop_front();
        chk("pulse_kind", {62'd0, cv_m, fe_m},
            {62'd0, ev.commit, !ev.commit});
        if (ev.commit) begin
          exp_out = ev.word;
          exp_cnt++;
        end
        chk("out_msb", 64'(out_m), 64'(exp_out));
        chk("cnt_msb", 64'(cnt_m), 64'(exp_cnt % 65536));
        chk("out_lsb", 64'(out_l), 64'(rev(exp_out)));
        chk("cnt_lsb", 64'(cnt_l), 64'(exp_cnt % 4));
        chk("pulse_lsb", {62'd0, cv_l, fe_l}, {62'd0, cv_m, fe_m});
      end
    end
  end

  task automatic send(input logic [N-1:0] w, input int len,
                      input int gap, input bit commit);
    ev_t ev;
    ev.commit = commit;
    ev.word   = w;
    sb.push_back(ev);
    for (int i = 0; i < len; i++) begin
      en = 1'b1;
      si = (i < N) ? w[N-1-i] : 1'b0;
      @(posedge CLK); #1;
      if (i == 0) chk("busy_first_bit", {63'd0, busy_m}, 64'd1);
    end
    en = 1'b0;
    si = 1'bx;
    @(posedge CLK); #1;
    if (len == N)
      chk("valid_latency", {63'd0, cv_m}, 64'd1);
    else if (len < N)
      chk("short_err_latency", {63'd0, fe_m}, 64'd1);
    else
      chk("overlong_busy_drop", {63'd0, busy_m}, 64'd0);
    chk("busy_after_frame", {63'd0, busy_m}, 64'd0);
    for (int g = 1; g < gap; g++) begin
      @(posedge CLK); #1;
    end
  endtask

  vec_t tbl[8];

  initial begin
    nchk    = 0;
    nerr    = 0;
    exp_out = '0;
    exp_cnt = 0;
    tbl[0] = '{55'h3AA55AA3FF,        55, 1, 1'b1};
    tbl[1] = '{55'h3AA55AA3FF,        54, 2, 1'b0};
    tbl[2] = '{55'h0,                 57, 1, 1'b0};
    tbl[3] = '{55'h1,                 55, 1, 1'b1};
    tbl[4] = '{55'h7FFFFFFFFFFFFF,    55, 1, 1'b1};
    tbl[5] = '{55'h55555555555555,    55, 3, 1'b1};
    tbl[6] = '{55'h7FFFFFFFFFFFFF,     1, 1, 1'b0};
    tbl[7] = '{55'h123456789ABCD,     55, 2, 1'b1};

    RST_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(0, 1));
      si = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("rst_out", 64'(out_m), 64'd0);
    chk("rst_flags", {60'd0, cv_m, fe_m, busy_m, 1'b0}, 64'd0);
    chk("rst_cnt", 64'(cnt_m), 64'd0);
    en = 1'b0;
    si = 1'bx;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int v = 0; v < 8; v++)
      send(tbl[v].word, tbl[v].len, tbl[v].gap, tbl[v].commit);
    chk("table_out", 64'(out_m), 64'(55'h123456789ABCD));
    chk("table_cnt", 64'(cnt_m), 64'd5);
    chk("table_cnt_wrap", 64'(cnt_l), 64'd1);

    // Async reset mid-frame after 30 bits
    for (int i = 0; i < 30; i++) begin
      en = 1'b1;
      si = 1'(i & 1);
      @(posedge CLK); #1;
    end
    #2;
    en    = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("async_rst_out", 64'(out_m), 64'd0);
    chk("async_rst_cnt", 64'(cnt_m), 64'd0);
    chk("async_rst_busy", {63'd0, busy_m}, 64'd0);
    exp_out = '0;
    exp_cnt = 0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    send(55'h2AAAAAAAAAAAAA, 55, 1, 1'b1);
    chk("post_rst_out", 64'(out_m), 64'(55'h2AAAAAAAAAAAAA));
    chk("post_rst_cnt", 64'(cnt_m), 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
